led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Upstream stage of the board LED driver. Produces the 8-bit per-LED on/off vector that the LED driver maps onto Red Pitaya LEDs 0-7.
- Each LED has its own run-time mode: OFF, ON, BLINK, STRETCH, PWM dim or FOLLOW. Modes are set through a single-word config write port.
- SPGD control logic uses it to show loop status, iteration heartbeat and error events without owning any timing itself.

Parameters:
- LED_WIDTH, 8, number of LED channels.
- TICK_DIV, 125000, clk_i cycles per timebase tick (1 ms at 125 MHz). Must be >= 2.
- PWM_BITS, 4, width of the PWM duty field and of the free-running PWM counter.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous, active-high reset.
- cfg_we_i  input  1  config write strobe, one cycle per write.
- cfg_addr_i  input  $clog2(LED_WIDTH)  LED index being written.
- cfg_mode_i  input  3  mode code: 0 OFF, 1 ON, 2 BLINK, 3 STRETCH, 4 PWM, 5 FOLLOW, 6-7 reserved.
- cfg_param_i  input  8  mode parameter: half-period ms (BLINK), hold ms (STRETCH), duty in low PWM_BITS (PWM).
- event_i  input  LED_WIDTH  per-LED event/level inputs, synchronous to clk_i.
- val_o  output  LED_WIDTH  LED on/off vector to the LED driver; 1 = on.
- tick_o  output  1  one-cycle timebase tick pulse, for debug.

Behaviour:
- Clocking and reset:
  - Single clock domain. rst_i is synchronous and active-high.
  - On reset: all modes = OFF, params = 0, ms counters = 0, phase bits = 0, prescaler = 0, PWM counter = 0, val_o = 0, tick_o = 0.
  - Asserting reset mid-blink or mid-stretch forces val_o to 0 on the next edge.
- Timebase:
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - tick_o is high for exactly one cycle, in the cycle the prescaler equals TICK_DIV-1.
  - The PWM counter is free-running, increments every clk_i and wraps at 2^PWM_BITS.
- Config writes:
  - When cfg_we_i is high and cfg_addr_i < LED_WIDTH, that channel's mode and param are registered on the edge.
  - The same write clears the channel's counter and phase bit.
  - The new mode drives val_o from the following cycle.
  - cfg_addr_i >= LED_WIDTH: the write is ignored.
  - A write and an event on the same channel in the same cycle: the write wins and the event is dropped.
- Effective param: for BLINK and STRETCH, param 0 is treated as 1.
- OFF: val_o[i] = 0. Reserved modes 6-7 behave as OFF.
- ON: val_o[i] = 1.
- BLINK:
  - On each tick, counter += 1.
  - When counter reaches param-1 on a tick, counter resets to 0 and the phase bit toggles.
  - val_o[i] = phase. After a config write, the LED is off for param ms, then on for param ms, and so on.
- STRETCH:
  - event_i[i] high in any cycle loads counter = param.
  - On a tick with counter > 0, counter -= 1.
  - val_o[i] = (counter != 0).
  - A retrigger while on reloads the full param.
  - Event and tick in the same cycle: the load wins and no decrement happens.
- PWM:
  - val_o[i] = (pwm_cnt < param[PWM_BITS-1:0]).
  - Duty 0 = always off. Duty 15 = on 15 of 16 cycles.
- FOLLOW: val_o[i] = event_i[i] registered.
- Latency:
  - All val_o bits are registered.
  - Event to output: 1 cycle (STRETCH, FOLLOW).
  - Config write to new behaviour: 1 cycle after the write edge.
- Width rules:
  - The 8-bit counter never exceeds param-1 (BLINK) or param (STRETCH).
  - No overflow is possible.

Decomposition:
- Package led_pattern_pkg holds:
  - mode localparams MODE_OFF, MODE_ON, MODE_BLINK, MODE_STRETCH, MODE_PWM, MODE_FOLLOW;
  - a mode-code width constant of 3;
  - a param width constant of 8.
- Sub-module led_channel:
  - one LED's mode/param registers, counter, phase bit and output register;
  - inputs: tick, pwm_cnt, event bit, and a qualified write strobe with mode/param.
- Top level holds the prescaler, the PWM counter, address decode, and a generate loop of LED_WIDTH led_channel instances.

Test Plan:
All scenarios run with TICK_DIV = 4.
1. Reset with event_i = 8'hFF, then ON written to LED 3 -> val_o = 8'h00 throughout reset, then 8'h08 one cycle after the write.
2. BLINK, param 2, written to LED 0 -> val_o[0] is low 8 cycles, high 8 cycles, repeating. tick_o pulses every 4 cycles.
3. STRETCH, param 3, on LED 5; 1-cycle event_i[5] -> val_o[5] goes high the next cycle and stays high until the third following tick. A retrigger during the hold extends it to 3 full ticks from the retrigger.
4. PWM, param 4, on LED 7 -> val_o[7] is high exactly 4 of every 16 cycles. Param 0 -> never high.
5. FOLLOW on LED 2 with event_i[2] toggled in a pattern -> val_o[2] reproduces the pattern delayed by 1 cycle. A simultaneous config write to LED 2 with an event pulse -> the event does not appear.
6. Write to cfg_addr_i beyond LED_WIDTH (LED_WIDTH=6 build, addr 7) -> no channel changes. Assert rst_i mid-BLINK -> val_o = 0 on the next edge and channel modes return to OFF.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared constants for the LED pattern generator: mode codes and field widths.
package led_pattern_pkg;

  localparam int MODE_W  = 3;
  localparam int PARAM_W = 8;

  localparam logic [MODE_W-1:0] MODE_OFF     = 3'd0;
  localparam logic [MODE_W-1:0] MODE_ON      = 3'd1;
  localparam logic [MODE_W-1:0] MODE_BLINK   = 3'd2;
  localparam logic [MODE_W-1:0] MODE_STRETCH = 3'd3;
  localparam logic [MODE_W-1:0] MODE_PWM     = 3'd4;
  localparam logic [MODE_W-1:0] MODE_FOLLOW  = 3'd5;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Config write port, event inputs and LED/tick outputs of the pattern generator.
interface led_pattern_gen_if
  import led_pattern_pkg::*;
#(
  parameter int LED_WIDTH = 8
);

  logic                         cfg_we_i;
  logic [$clog2(LED_WIDTH)-1:0] cfg_addr_i;
  logic [MODE_W-1:0]            cfg_mode_i;
  logic [PARAM_W-1:0]           cfg_param_i;
  logic [LED_WIDTH-1:0]         event_i;
  logic [LED_WIDTH-1:0]         val_o;
  logic                         tick_o;

  modport master (
    output cfg_we_i, cfg_addr_i, cfg_mode_i, cfg_param_i, event_i,
    input  val_o, tick_o
  );

  modport slave (
    input  cfg_we_i, cfg_addr_i, cfg_mode_i, cfg_param_i, event_i,
    output val_o, tick_o
  );

endinterface

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: mode/param registers, ms counter, blink phase and the
// registered on/off output.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int PWM_BITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tick_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                event_i,
  input  logic                wr_i,
  input  logic [MODE_W-1:0]   mode_i,
  input  logic [PARAM_W-1:0]  param_i,
  output logic                val_o
);

  logic [MODE_W-1:0]  mode_q,  mode_d;
  logic [PARAM_W-1:0] param_q, param_d;
  logic [PARAM_W-1:0] cnt_q,   cnt_d;
  logic               phase_q, phase_d;
  logic               val_q,   val_d;
  logic               ev;
  logic [PARAM_W-1:0] eff;

  // A zero period/hold would never advance, so it is run as 1 ms.
  function automatic logic [PARAM_W-1:0] eff_param(input logic [PARAM_W-1:0] p);
    return (p == '0) ? PARAM_W'(1) : p;
  endfunction

  // Next-state: a config write overrides everything else on this channel,
  // and the output is computed from the next state so it is registered.
  always_comb begin
    mode_d  = mode_q;
    param_d = param_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    val_d   = 1'b0;
    ev      = event_i & ~wr_i;
    eff     = eff_param(param_q);

    if (wr_i) begin
      mode_d  = mode_i;
      param_d = param_i;
      cnt_d   = '0;
      phase_d = 1'b0;
    end else begin
      case (mode_q)
        MODE_BLINK: begin
          if (tick_i) begin
            if (cnt_q >= eff - PARAM_W'(1)) begin
              cnt_d   = '0;
              phase_d = ~phase_q;
            end else begin
              cnt_d = cnt_q + PARAM_W'(1);
            end
          end
        end
        MODE_STRETCH: begin
          if (event_i) begin
            cnt_d = eff;
          end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - PARAM_W'(1);
          end
        end
        default: ;
      endcase
    end

    case (mode_d)
      MODE_ON:      val_d = 1'b1;
      MODE_BLINK:   val_d = phase_d;
      MODE_STRETCH: val_d = (cnt_d != '0);
      MODE_PWM:     val_d = (pwm_cnt_i < param_d[PWM_BITS-1:0]);
      MODE_FOLLOW:  val_d = ev;
      default:      val_d = 1'b0;
    endcase
  end

  // Channel state registers with synchronous reset to OFF.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q  <= MODE_OFF;
      param_q <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      param_q <= param_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      val_q   <= val_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator top: ms timebase, free-running PWM counter, config
// address decode and one led_channel per LED.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int LED_WIDTH = 8,
  parameter int TICK_DIV  = 125000,
  parameter int PWM_BITS  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  led_pattern_gen_if.slave bus
);

  localparam int AW      = $clog2(LED_WIDTH);
  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [PWM_BITS-1:0]  pwm_q,   pwm_d;
  logic                 tick;
  logic                 addr_ok;
  logic [LED_WIDTH-1:0] val;

  // Prescaler wrap and PWM counter increment.
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    pwm_d   = pwm_q + PWM_BITS'(1);
    addr_ok = (int'(bus.cfg_addr_i) < LED_WIDTH);
  end

  // Timebase registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
      pwm_q   <= '0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
    end
  end

  for (genvar i = 0; i < LED_WIDTH; i++) begin : g_ch
    logic wr;
    assign wr = bus.cfg_we_i && addr_ok && (bus.cfg_addr_i == AW'(i));

    led_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .tick_i    (tick),
      .pwm_cnt_i (pwm_q),
      .event_i   (bus.event_i[i]),
      .wr_i      (wr),
      .mode_i    (bus.cfg_mode_i),
      .param_i   (bus.cfg_param_i),
      .val_o     (val[i])
    );
  end

  assign bus.val_o  = val;
  assign bus.tick_o = tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with TICK_DIV = 4: an 8-LED and a 6-LED
// instance share clock and reset.
module tb_led_pattern_gen;
  import led_pattern_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  led_pattern_gen_if #(.LED_WIDTH(8)) i8 ();
  led_pattern_gen_if #(.LED_WIDTH(6)) i6 ();

  led_pattern_gen #(.LED_WIDTH(8), .TICK_DIV(4), .PWM_BITS(4)) dut8 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (i8)
  );

  led_pattern_gen #(.LED_WIDTH(6), .TICK_DIV(4), .PWM_BITS(4)) dut6 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (i6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write8(input logic [2:0] addr, input logic [2:0] mode, input logic [7:0] param);
    i8.cfg_we_i    = 1'b1;
    i8.cfg_addr_i  = addr;
    i8.cfg_mode_i  = mode;
    i8.cfg_param_i = param;
    step();
    i8.cfg_we_i    = 1'b0;
  endtask

  task automatic write6(input logic [2:0] addr, input logic [2:0] mode, input logic [7:0] param);
    i6.cfg_we_i    = 1'b1;
    i6.cfg_addr_i  = addr;
    i6.cfg_mode_i  = mode;
    i6.cfg_param_i = param;
    step();
    i6.cfg_we_i    = 1'b0;
  endtask

  task automatic align_tick();
    int w;
    w = 0;
    while (!i8.tick_o && w < 8) begin
      step();
      w++;
    end
    check("align_tick", 32'(i8.tick_o), 32'd1);
  endtask

  logic        s_val[48];
  logic        s_tick[48];
  int          tfirst;
  int          ftick;
  int          cnt;
  logic [11:0] pat;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    i8.cfg_we_i = 1'b0; i8.cfg_addr_i = '0; i8.cfg_mode_i = '0; i8.cfg_param_i = '0;
    i8.event_i  = 8'hFF;
    i6.cfg_we_i = 1'b0; i6.cfg_addr_i = '0; i6.cfg_mode_i = '0; i6.cfg_param_i = '0;
    i6.event_i  = 6'h3F;

    // 1: reset, then ON to LED 3
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_val8", 32'(i8.val_o), 32'h00);
      check("rst_tick", 32'(i8.tick_o), 32'd0);
    end
    rst = 1'b0;
    step();
    check("post_rst_val8", 32'(i8.val_o), 32'h00);
    check("post_rst_val6", 32'(i6.val_o), 32'h00);
    i8.event_i = '0;
    i6.event_i = '0;
    write8(3'd3, MODE_ON, 8'd0);
    check("on_led3", 32'(i8.val_o), 32'h08);

    // 2: BLINK param 2 on LED 0, tick period
    write8(3'd0, MODE_BLINK, 8'd2);
    check("blink_start", 32'(i8.val_o), 32'h08);
    s_val[0]  = i8.val_o[0];
    s_tick[0] = i8.tick_o;
    for (int k = 1; k < 48; k++) begin
      step();
      s_val[k]  = i8.val_o[0];
      s_tick[k] = i8.tick_o;
    end
    cnt = 0;
    for (int k = 0; k < 16; k++) cnt += int'(s_tick[k]);
    check("tick_count16", 32'(cnt), 32'd4);
    ftick = 0;
    for (int k = 3; k >= 0; k--) if (s_tick[k]) ftick = k;
    check("tick_period", 32'(s_tick[ftick + 4]), 32'd1);
    check("tick_one_cycle", 32'(s_tick[ftick + 1]), 32'd0);
    tfirst = -1;
    for (int k = 47; k >= 0; k--) if (s_val[k]) tfirst = k;
    check("blink_first_on", 32'(tfirst >= 5 && tfirst <= 8), 32'd1);
    if (tfirst < 0 || tfirst > 16) tfirst = 5;
    for (int k = 0; k < 32; k++)
      check("blink_pattern", 32'(s_val[tfirst + k]), 32'((k < 8) || (k >= 16 && k < 24)));

    // 3: STRETCH param 3 on LED 5, single trigger then retrigger
    write8(3'd5, MODE_STRETCH, 8'd3);
    check("stretch_idle", 32'(i8.val_o[5]), 32'd0);
    align_tick();
    i8.event_i[5] = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      i8.event_i[5] = 1'b0;
      check("stretch_single", 32'(i8.val_o[5]), 32'(k <= 11));
    end
    align_tick();
    i8.event_i[5] = 1'b1;
    for (int k = 0; k < 18; k++) begin
      step();
      check("stretch_retrig", 32'(i8.val_o[5]), 32'(k <= 15));
      i8.event_i[5] = (k == 5);
    end

    // 4: PWM duty 4, 0 and 15 on LED 7
    write8(3'd7, MODE_PWM, 8'd4);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      cnt += int'(i8.val_o[7]);
      step();
    end
    check("pwm_duty4", 32'(cnt), 32'd4);
    write8(3'd7, MODE_PWM, 8'd0);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      cnt += int'(i8.val_o[7]);
      step();
    end
    check("pwm_duty0", 32'(cnt), 32'd0);
    write8(3'd7, MODE_PWM, 8'hFF);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      cnt += int'(i8.val_o[7]);
      step();
    end
    check("pwm_duty15", 32'(cnt), 32'd15);

    // 5: FOLLOW on LED 2, then write colliding with an event
    write8(3'd2, MODE_FOLLOW, 8'd0);
    pat = 12'b1011_0010_0110;
    for (int k = 0; k < 12; k++) begin
      i8.event_i[2] = pat[k];
      step();
      check("follow", 32'(i8.val_o[2]), 32'(pat[k]));
    end
    i8.event_i[2] = 1'b1;
    write8(3'd2, MODE_FOLLOW, 8'd0);
    check("follow_write_drop", 32'(i8.val_o[2]), 32'd0);
    step();
    check("follow_resume", 32'(i8.val_o[2]), 32'd1);
    i8.event_i[2] = 1'b0;

    // 6: out-of-range address on 6-LED build, reset mid-blink
    write6(3'd4, MODE_ON, 8'd0);
    check("w6_led4", 32'(i6.val_o), 32'h10);
    write6(3'd6, MODE_ON, 8'd0);
    check("w6_addr6_ignored", 32'(i6.val_o), 32'h10);
    write6(3'd7, MODE_ON, 8'd0);
    check("w6_addr7_ignored", 32'(i6.val_o), 32'h10);
    step();
    check("w6_stable", 32'(i6.val_o), 32'h10);

    cnt = 0;
    while (!i8.val_o[0] && cnt < 20) begin
      step();
      cnt++;
    end
    check("blink_on_before_rst", 32'(i8.val_o[0]), 32'd1);
    rst = 1'b1;
    step();
    check("rst_mid_blink_val8", 32'(i8.val_o), 32'h00);
    check("rst_mid_val6", 32'(i6.val_o), 32'h00);
    rst = 1'b0;
    i8.event_i = 8'hFF;
    i6.event_i = 6'h3F;
    for (int k = 0; k < 8; k++) begin
      step();
      check("modes_off_val8", 32'(i8.val_o), 32'h00);
      check("modes_off_val6", 32'(i6.val_o), 32'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
